// File: rtl/pte_cache_ctrl_pkg.sv
// rtl/pte_cache_ctrl_pkg.sv - shared widths and FSM state type for the PTW PTE cache
package ptw_pkg;
    localparam int PADDR_W = 50;
    localparam int TAG_W   = 32;
    localparam int PTE_W   = 64;
    localparam int ENTRIES = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_REQ,
        MEM_WAIT,
        RESP
    } state_t;
endpackage

// File: rtl/pte_cache_ctrl_if.sv
// rtl/pte_cache_ctrl_if.sv - PTW lookup, response, memory read and flush signals
interface pte_cache_ctrl_if;
    import ptw_pkg::*;

    logic               req_valid;
    logic               req_ready;
    logic [PADDR_W-1:0] req_addr;
    logic [1:0]         req_level;
    logic               resp_valid;
    logic               resp_ready;
    logic [PTE_W-1:0]   resp_pte;
    logic               resp_hit;
    logic               mem_req_valid;
    logic               mem_req_ready;
    logic [PADDR_W-1:0] mem_req_addr;
    logic               mem_resp_valid;
    logic [PTE_W-1:0]   mem_resp_data;
    logic               flush;

    modport slave (
        input  req_valid, req_addr, req_level, resp_ready,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, flush,
        output req_ready, resp_valid, resp_pte, resp_hit,
        output mem_req_valid, mem_req_addr
    );

    modport master (
        output req_valid, req_addr, req_level, resp_ready,
        output mem_req_ready, mem_resp_valid, mem_resp_data, flush,
        input  req_ready, resp_valid, resp_pte, resp_hit,
        input  mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/pte_cache_ctrl_hit_judge.sv
// rtl/pte_cache_ctrl_hit_judge.sv - 8-way tag compare producing per-entry hit bits
module cache_hit_judge_unit
    import ptw_pkg::*;
(
    input  logic [1:0]         count,
    input  logic [7:0]         valid,
    input  logic [PADDR_W-1:0] pte_addr,
    input  logic [TAG_W-1:0]   tag_0,
    input  logic [TAG_W-1:0]   tag_1,
    input  logic [TAG_W-1:0]   tag_2,
    input  logic [TAG_W-1:0]   tag_3,
    input  logic [TAG_W-1:0]   tag_4,
    input  logic [TAG_W-1:0]   tag_5,
    input  logic [TAG_W-1:0]   tag_6,
    input  logic [TAG_W-1:0]   tag_7,
    output logic               pte_cache_hit,
    output logic [7:0]         hit_bit
);
    logic [TAG_W-1:0] tags [8];
    logic             upper_zero;

    assign tags[0] = tag_0;
    assign tags[1] = tag_1;
    assign tags[2] = tag_2;
    assign tags[3] = tag_3;
    assign tags[4] = tag_4;
    assign tags[5] = tag_5;
    assign tags[6] = tag_6;
    assign tags[7] = tag_7;

    // Stored tags drop the high address bits, so an address using them can never match.
    assign upper_zero = (pte_addr[PADDR_W-1:TAG_W] == '0);

    always_comb begin
        hit_bit = '0;
        for (int i = 0; i < 8; i++) begin
            hit_bit[i] = valid[i] && upper_zero && (tags[i] == pte_addr[TAG_W-1:0]);
        end
    end

    assign pte_cache_hit = (|hit_bit) && (count < 2'd2);
endmodule

// File: rtl/pte_cache_ctrl.sv
// rtl/pte_cache_ctrl.sv - PTE cache sequencing FSM with refill, round-robin victim and flush
module pte_cache_ctrl
    import ptw_pkg::*;
(
    input logic              clk,
    input logic              rst_n,
    pte_cache_ctrl_if.slave  bus
);
    state_t             state;
    logic [7:0]         valid_q;
    logic [2:0]         rr_ptr;
    logic               kill;
    logic [PADDR_W-1:0] addr_q;
    logic [1:0]         level_q;
    logic [TAG_W-1:0]   tag_q  [ENTRIES];
    logic [PTE_W-1:0]   data_q [ENTRIES];

    logic       hit;
    logic [7:0] hit_bit;
    logic [2:0] hit_idx;
    logic [2:0] victim;
    logic       refill_en;

    cache_hit_judge_unit u_judge (
        .count         (level_q),
        .valid         (valid_q),
        .pte_addr      (addr_q),
        .tag_0         (tag_q[0]),
        .tag_1         (tag_q[1]),
        .tag_2         (tag_q[2]),
        .tag_3         (tag_q[3]),
        .tag_4         (tag_q[4]),
        .tag_5         (tag_q[5]),
        .tag_6         (tag_q[6]),
        .tag_7         (tag_q[7]),
        .pte_cache_hit (hit),
        .hit_bit       (hit_bit)
    );

    // Descending scans so the lowest index wins in both encoders.
    always_comb begin
        hit_idx = 3'd0;
        victim  = rr_ptr;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (hit_bit[i]) hit_idx = 3'(i);
            if (!valid_q[i]) victim = 3'(i);
        end
    end

    assign refill_en = (state == MEM_WAIT) && bus.mem_resp_valid && !kill && !bus.flush
                    && (level_q < 2'd2) && (addr_q[PADDR_W-1:TAG_W] == '0);

    always_ff @(posedge clk) begin
        if (refill_en) begin
            tag_q[victim]  <= addr_q[TAG_W-1:0];
            data_q[victim] <= bus.mem_resp_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            valid_q           <= '0;
            rr_ptr            <= '0;
            kill              <= 1'b0;
            addr_q            <= '0;
            level_q           <= '0;
            bus.req_ready     <= 1'b1;
            bus.resp_valid    <= 1'b0;
            bus.resp_hit      <= 1'b0;
            bus.resp_pte      <= '0;
            bus.mem_req_valid <= 1'b0;
            bus.mem_req_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q        <= bus.req_addr;
                        level_q       <= bus.req_level;
                        bus.req_ready <= 1'b0;
                        state         <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit && !bus.flush) begin
                        bus.resp_pte   <= data_q[hit_idx];
                        bus.resp_hit   <= 1'b1;
                        bus.resp_valid <= 1'b1;
                        state          <= RESP;
                    end else begin
                        bus.mem_req_valid <= 1'b1;
                        bus.mem_req_addr  <= addr_q;
                        state             <= MEM_REQ;
                    end
                end
                MEM_REQ: begin
                    if (bus.flush) kill <= 1'b1;
                    if (bus.mem_req_ready) begin
                        bus.mem_req_valid <= 1'b0;
                        state             <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (bus.flush) kill <= 1'b1;
                    if (bus.mem_resp_valid) begin
                        bus.resp_pte   <= bus.mem_resp_data;
                        bus.resp_hit   <= 1'b0;
                        bus.resp_valid <= 1'b1;
                        state          <= RESP;
                        if (refill_en) begin
                            valid_q[victim] <= 1'b1;
                            if (&valid_q) rr_ptr <= rr_ptr + 3'd1;
                        end
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        bus.req_ready  <= 1'b1;
                        kill           <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // Flush overrides any refill landing on the same edge.
            if (bus.flush) valid_q <= '0;
        end
    end
endmodule

// File: tb/tb_pte_cache_ctrl.sv
// tb/tb_pte_cache_ctrl.sv - scoreboard bench for pte_cache_ctrl
module tb_pte_cache_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pte_cache_ctrl_if bus ();
    pte_cache_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    typedef struct {
        logic        hit;
        logic [63:0] pte;
    } exp_t;

    exp_t exp_q[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int resp_cnt = 0;
    int issued = 0;
    int mem_reads = 0;
    int acc_cyc = 0;
    int resp_first_cyc = 0;
    int mem_resp_cyc = 0;
    int mem_stall = 0;
    int resp_stall = 0;
    logic        flush_in_wait = 1'b0;
    logic [63:0] mem_data = '0;
    logic [49:0] exp_mem_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory responder: handshake after mem_stall cycles, data two cycles later.
    initial begin
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        bus.flush          = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.mem_req_valid) begin
                mem_reads++;
                chk("mem_req_addr", 64'(bus.mem_req_addr), 64'(exp_mem_addr));
                for (int k = 0; k < mem_stall; k++) begin
                    @(negedge clk);
                    chk("mem_valid_stable", 64'(bus.mem_req_valid), 64'd1);
                    chk("mem_addr_stable", 64'(bus.mem_req_addr), 64'(exp_mem_addr));
                end
                bus.mem_req_ready = 1'b1;
                @(negedge clk);
                bus.mem_req_ready = 1'b0;
                if (flush_in_wait) bus.flush = 1'b1;
                @(negedge clk);
                bus.flush          = 1'b0;
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_data  = mem_data;
                mem_resp_cyc       = cyc;
                @(negedge clk);
                bus.mem_resp_valid = 1'b0;
            end
        end
    end

    // Response monitor: applies resp_stall backpressure, then pops and compares.
    initial begin
        automatic logic in_resp = 1'b0;
        automatic int stall_cnt = 0;
        exp_t e;
        bus.resp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.resp_valid) begin
                if (!in_resp) begin
                    in_resp = 1'b1;
                    resp_first_cyc = cyc;
                    stall_cnt = 0;
                end
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_resp: got pte %0h with empty scoreboard", bus.resp_pte);
                    bus.resp_ready = 1'b1;
                    in_resp = 1'b0;
                end else if (stall_cnt < resp_stall) begin
                    chk("resp_pte_held", bus.resp_pte, exp_q[0].pte);
                    chk("req_ready_busy", 64'(bus.req_ready), 64'd0);
                    stall_cnt++;
                    bus.resp_ready = 1'b0;
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_pte", bus.resp_pte, e.pte);
                    chk("resp_hit", 64'(bus.resp_hit), 64'(e.hit));
                    bus.resp_ready = 1'b1;
                    in_resp = 1'b0;
                    resp_cnt++;
                end
            end else begin
                bus.resp_ready = 1'b0;
            end
        end
    end

    task automatic do_req(input logic [49:0] addr, input logic [1:0] lvl,
                          input logic exp_hit, input logic [63:0] exp_pte);
        exp_t e;
        int n;
        e.hit = exp_hit;
        e.pte = exp_pte;
        exp_q.push_back(e);
        issued++;
        exp_mem_addr = addr;
        @(negedge clk);
        chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_level = lvl;
        acc_cyc = cyc;
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (resp_cnt < issued && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (resp_cnt < issued) begin
            tests++;
            fails++;
            $display("FAIL resp_timeout: got %0d responses expected %0d", resp_cnt, issued);
            resp_cnt = issued;
        end
        @(negedge clk);
    endtask

    initial begin
        int reads0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_level = '0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_hit", 64'(bus.resp_hit), 64'd0);
        chk("rst_resp_pte", bus.resp_pte, 64'd0);
        chk("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        chk("rst_mem_req_addr", 64'(bus.mem_req_addr), 64'd0);
        chk("rst_valid", 64'(dut.valid_q), 64'h00);
        chk("rst_rr_ptr", 64'(dut.rr_ptr), 64'd0);
        rst_n = 1'b1;

        mem_data = 64'hA5;
        do_req(50'h1000, 2'd0, 1'b0, 64'hA5);
        chk("cold_valid", 64'(dut.valid_q), 64'h01);
        chk("miss_latency", 64'(resp_first_cyc - mem_resp_cyc), 64'd1);

        reads0 = mem_reads;
        do_req(50'h1000, 2'd0, 1'b1, 64'hA5);
        chk("hit_no_mem", 64'(mem_reads), 64'(reads0));
        chk("hit_latency", 64'(resp_first_cyc - acc_cyc), 64'd2);

        mem_data = 64'h77;
        do_req(50'h1000, 2'd2, 1'b0, 64'h77);
        chk("level2_mem_read", 64'(mem_reads), 64'(reads0 + 1));
        chk("level2_valid", 64'(dut.valid_q), 64'h01);

        mem_data = 64'h88;
        do_req(50'h4_0000_0000, 2'd0, 1'b0, 64'h88);
        chk("uncache_mem_read", 64'(mem_reads), 64'(reads0 + 2));
        chk("uncache_valid", 64'(dut.valid_q), 64'h01);

        for (int i = 2; i <= 8; i++) begin
            mem_data = 64'(i) << 8;
            do_req(50'(i) << 12, 2'd0, 1'b0, 64'(i) << 8);
        end
        chk("fill_valid", 64'(dut.valid_q), 64'hFF);
        chk("fill_rr_ptr", 64'(dut.rr_ptr), 64'd0);

        mem_data = 64'h900;
        do_req(50'h9000, 2'd0, 1'b0, 64'h900);
        chk("replace_rr_ptr", 64'(dut.rr_ptr), 64'd1);
        chk("replace_valid", 64'(dut.valid_q), 64'hFF);

        mem_data = 64'h1A5;
        do_req(50'h1000, 2'd0, 1'b0, 64'h1A5);
        chk("evicted_rr_ptr", 64'(dut.rr_ptr), 64'd2);
        do_req(50'h3000, 2'd0, 1'b1, 64'h300);
        do_req(50'h9000, 2'd0, 1'b1, 64'h900);

        flush_in_wait = 1'b1;
        mem_data = 64'hBEEF;
        do_req(50'hA000, 2'd0, 1'b0, 64'hBEEF);
        flush_in_wait = 1'b0;
        chk("flush_valid", 64'(dut.valid_q), 64'h00);
        chk("flush_rr_ptr", 64'(dut.rr_ptr), 64'd2);
        reads0 = mem_reads;
        mem_data = 64'hC0DE;
        do_req(50'hA000, 2'd0, 1'b0, 64'hC0DE);
        chk("post_flush_miss", 64'(mem_reads), 64'(reads0 + 1));
        chk("post_flush_valid", 64'(dut.valid_q), 64'h01);

        mem_stall  = 5;
        resp_stall = 3;
        mem_data = 64'h1234;
        do_req(50'hB000, 2'd1, 1'b0, 64'h1234);
        mem_stall  = 0;
        resp_stall = 0;
        chk("bp_valid", 64'(dut.valid_q), 64'h03);
        do_req(50'hB000, 2'd1, 1'b1, 64'h1234);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
